// File: rtl/ram_io_responder_pkg.sv
// Shared definitions for the RAM/MMIO responder: bus encodings, MMIO map,
// status bit layout and the read-source select type.
package ram_io_responder_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int RAM_WIDTH  = 8;

  // Read/write flag encoding on the controller bus
  localparam logic RAM_RD = 1'b0;
  localparam logic RAM_WT = 1'b1;

  // MMIO offsets relative to IO_BASE
  localparam logic [DATA_WIDTH-1:0] IO_DATA   = 32'd0;
  localparam logic [DATA_WIDTH-1:0] IO_STATUS = 32'd4;
  localparam logic [DATA_WIDTH-1:0] IO_CYCLE  = 32'd8;

  // Status byte bit positions
  localparam int STATUS_TX_FULL     = 0;
  localparam int STATUS_RX_NONEMPTY = 1;

  // Which register bank drives the read data
  typedef enum logic {
    SRC_RAM  = 1'b0,
    SRC_MMIO = 1'b1
  } read_src_e;

  function automatic logic [RAM_WIDTH-1:0] status_byte(input logic rx_nonempty,
                                                       input logic tx_full);
    logic [RAM_WIDTH-1:0] s;
    s = '0;
    s[STATUS_RX_NONEMPTY] = rx_nonempty;
    s[STATUS_TX_FULL]     = tx_full;
    return s;
  endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Byte-wide RAM bus between the memory controller (master) and the
// responder (slave).
interface ram_io_responder_if;
  import ram_io_responder_pkg::*;

  logic                  in_ram_ena;
  logic                  in_ram_rd_wt_flag;
  logic [DATA_WIDTH-1:0] in_ram_addr;
  logic [RAM_WIDTH-1:0]  in_ram_data;
  logic [RAM_WIDTH-1:0]  out_ram_data;

  modport master (
    output in_ram_ena, in_ram_rd_wt_flag, in_ram_addr, in_ram_data,
    input  out_ram_data
  );

  modport slave (
    input  in_ram_ena, in_ram_rd_wt_flag, in_ram_addr, in_ram_data,
    output out_ram_data
  );
endinterface

// File: rtl/ram_io_responder_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with first-word-fall-through head.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder: serves controller byte requests from an internal
// synchronous RAM (below IO_BASE) or memory-mapped I/O (at/above IO_BASE):
// host TX/RX byte streams, a status byte and a sticky halt flag.
// Optional build macro CYCLE_COUNTER_EN adds a 32-bit cycle counter readable
// at offsets 8..11 with a snapshot taken on the offset-8 read.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int                    ADDR_BITS  = 17,
  parameter int                    FIFO_DEPTH = 8,
  parameter logic [DATA_WIDTH-1:0] IO_BASE    = 32'h30000
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_io_responder_if.slave    bus,
  output logic                 out_tx_valid,
  output logic [RAM_WIDTH-1:0] out_tx_data,
  input  logic                 in_tx_ready,
  input  logic                 in_rx_valid,
  input  logic [RAM_WIDTH-1:0] in_rx_data,
  output logic                 out_rx_ready,
  output logic                 out_io_full,
  output logic                 out_halt
);

  logic [RAM_WIDTH-1:0]  ram [2**ADDR_BITS];
  logic [ADDR_BITS-1:0]  ram_idx;
  logic [RAM_WIDTH-1:0]  ram_q;
  logic [RAM_WIDTH-1:0]  mmio_q;
  logic [RAM_WIDTH-1:0]  mmio_rd;
  read_src_e             sel_q;
  logic [DATA_WIDTH-1:0] io_off;
  logic                  is_io;
  logic                  is_rd;
  logic                  is_wt;
  logic                  ram_we;
  logic                  ram_re;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  rx_pop;
  logic                  rx_full;
  logic                  rx_empty;
  logic [RAM_WIDTH-1:0]  rx_head;

  assign is_io   = (bus.in_ram_addr >= IO_BASE);
  assign io_off  = bus.in_ram_addr - IO_BASE;
  assign ram_idx = bus.in_ram_addr[ADDR_BITS-1:0];
  assign is_rd   = bus.in_ram_ena && (bus.in_ram_rd_wt_flag == RAM_RD);
  assign is_wt   = bus.in_ram_ena && (bus.in_ram_rd_wt_flag == RAM_WT);
  assign ram_we  = is_wt && !is_io && !rst;
  assign ram_re  = is_rd && !is_io && !rst;

  assign tx_push = is_wt && is_io && (io_off == IO_DATA);
  assign tx_pop  = out_tx_valid && in_tx_ready;
  assign rx_pop  = is_rd && is_io && (io_off == IO_DATA);

  assign out_tx_valid = !tx_empty;
  assign out_io_full  = tx_full;
  assign out_rx_ready = !rx_full;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (bus.in_ram_data),
    .pop       (tx_pop),
    .head      (out_tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_rx_valid),
    .push_data (in_rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
  logic [31:0] cycle_snap;

  // Free-running cycle counter; offset-8 read freezes the full value for bytes 1..3
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt  <= '0;
      cycle_snap <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (is_rd && is_io && (io_off == IO_CYCLE)) cycle_snap <= cycle_cnt;
    end
  end
`endif

  // MMIO read mux evaluated on the request cycle
  always_comb begin
    mmio_rd = '0;
    case (io_off)
      IO_DATA:          mmio_rd = rx_empty ? '0 : rx_head;
      IO_STATUS:        mmio_rd = status_byte(!rx_empty, tx_full);
`ifdef CYCLE_COUNTER_EN
      IO_CYCLE:         mmio_rd = cycle_cnt[7:0];
      IO_CYCLE + 32'd1: mmio_rd = cycle_snap[15:8];
      IO_CYCLE + 32'd2: mmio_rd = cycle_snap[23:16];
      IO_CYCLE + 32'd3: mmio_rd = cycle_snap[31:24];
`endif
      default:          mmio_rd = '0;
    endcase
  end

  // Byte RAM: write-first visibility to the next cycle, registered read port
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.in_ram_data;
    if (ram_re) ram_q <= ram[ram_idx];
  end

  // Read source select, MMIO read register and sticky halt flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= SRC_MMIO;
      mmio_q   <= '0;
      out_halt <= 1'b0;
    end else begin
      if (is_rd) begin
        sel_q <= is_io ? SRC_MMIO : SRC_RAM;
        if (is_io) mmio_q <= mmio_rd;
      end
      if (is_wt && is_io && (io_off == IO_STATUS)) out_halt <= 1'b1;
    end
  end

  assign bus.out_ram_data = (sel_q == SRC_RAM) ? ram_q : mmio_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: stimulus pushes expected read bytes
// and TX stream bytes into queues, a monitor pops and compares them.
module tb_ram_io_responder;
  import ram_io_responder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out_tx_valid;
  logic [7:0] out_tx_data;
  logic       in_tx_ready = 1'b0;
  logic       in_rx_valid = 1'b0;
  logic [7:0] in_rx_data  = 8'h00;
  logic       out_rx_ready;
  logic       out_io_full;
  logic       out_halt;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rd_q [$];
  logic [7:0]  tx_q [$];
  logic        rd_fire = 1'b0;
  logic [31:0] ref_cnt;

  ram_io_responder_if bus();

  ram_io_responder dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .out_tx_valid (out_tx_valid),
    .out_tx_data  (out_tx_data),
    .in_tx_ready  (in_tx_ready),
    .in_rx_valid  (in_rx_valid),
    .in_rx_data   (in_rx_data),
    .out_rx_ready (out_rx_ready),
    .out_io_full  (out_io_full),
    .out_halt     (out_halt)
  );

  always #5 clk = ~clk;

  // Reference cycle count, used only for the optional counter readback
  always @(posedge clk or posedge rst) begin
    if (rst) ref_cnt <= 32'd0;
    else     ref_cnt <= ref_cnt + 32'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A read is in flight for exactly the cycle after it was sampled
  always @(posedge clk) begin
    rd_fire <= (bus.in_ram_ena === 1'b1) && (bus.in_ram_rd_wt_flag === RAM_RD) && !rst;
  end

  // Monitor: compare read data and TX stream bytes against the queues
  always @(negedge clk) begin
    if (rd_fire) begin
      if (rd_q.size() == 0) checkOutput("rd_unexpected", 32'd1, 32'd0);
      else checkOutput("rd_data", {24'd0, bus.out_ram_data}, {24'd0, rd_q.pop_front()});
    end
    if (out_tx_valid === 1'b1 && in_tx_ready === 1'b1) begin
      if (tx_q.size() == 0) checkOutput("tx_unexpected", {24'd0, out_tx_data}, 32'hFFFF_FFFF);
      else checkOutput("tx_data", {24'd0, out_tx_data}, {24'd0, tx_q.pop_front()});
    end
  end

  task automatic applyStimulus(input logic en, input logic wt, input logic [31:0] addr,
                               input logic [7:0] data, input logic [7:0] exp_rd);
    @(posedge clk); #1;
    bus.in_ram_ena        = en;
    bus.in_ram_rd_wt_flag = wt ? RAM_WT : RAM_RD;
    bus.in_ram_addr       = addr;
    bus.in_ram_data       = data;
    if (en && !wt) rd_q.push_back(exp_rd);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b1, addr, data, 8'h00);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] exp);
    applyStimulus(1'b1, 1'b0, addr, 8'h00, exp);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 8'h00);
  endtask

  task automatic waitTxDrain();
    for (int i = 0; i < 40 && tx_q.size() != 0; i++) @(posedge clk);
    if (tx_q.size() != 0) checkOutput("tx_drain_timeout", tx_q.size(), 32'd0);
    #1;
    checkOutput("tx_valid_after_drain", {31'd0, out_tx_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] snap;
    bus.in_ram_ena = 1'b0;
    bus.in_ram_rd_wt_flag = RAM_RD;
    bus.in_ram_addr = 32'h0;
    bus.in_ram_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset_ram_data", {24'd0, bus.out_ram_data}, 32'd0);
    checkOutput("reset_halt", {31'd0, out_halt}, 32'd0);
    checkOutput("reset_tx_valid", {31'd0, out_tx_valid}, 32'd0);
    checkOutput("reset_rx_ready", {31'd0, out_rx_ready}, 32'd1);
    checkOutput("reset_io_full", {31'd0, out_io_full}, 32'd0);

    // RAM write then read back, aliasing and the last address below IO_BASE
    wr(32'h0001_0, 8'hA5);
    rd(32'h0001_0, 8'hA5);
    wr(32'h2_0004, 8'h3C);
    wr(32'h2_FFFF, 8'h6B);
    wr(32'h0000_0100, 8'h55);
    rd(32'h0_FFFF, 8'h6B);
    rd(32'h0_0004, 8'h3C);
    idle();
    idle();
    checkOutput("ram_data_hold", {24'd0, bus.out_ram_data}, 32'h3C);

    // TX stream with backpressure: 9th byte dropped while full
    in_tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      wr(32'h3_0000, 8'(i));
      if (i <= 8) tx_q.push_back(8'(i));
      if (i == 8) checkOutput("io_full_after_7", {31'd0, out_io_full}, 32'd0);
      if (i == 9) checkOutput("io_full_after_8", {31'd0, out_io_full}, 32'd1);
    end
    rd(32'h3_0004, 8'h01);
    idle();
    in_tx_ready = 1'b1;
    waitTxDrain();
    checkOutput("io_full_drained", {31'd0, out_io_full}, 32'd0);

    // TX full with a host pop in the same cycle still accepts a bus push
    in_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(32'h3_0000, 8'h11 + 8'(i));
      tx_q.push_back(8'h11 + 8'(i));
    end
    wr(32'h3_0000, 8'hAA);
    checkOutput("io_full_before_pop", {31'd0, out_io_full}, 32'd1);
    in_tx_ready = 1'b1;
    tx_q.push_back(8'hAA);
    idle();
    waitTxDrain();

    // RX stream: two host bytes, status, then pops down to empty
    idle(); in_rx_valid = 1'b1; in_rx_data = 8'h41;
    idle(); in_rx_data = 8'h42;
    rd(32'h3_0004, 8'h02); in_rx_valid = 1'b0;
    rd(32'h3_0000, 8'h41);
    rd(32'h3_0000, 8'h42);
    rd(32'h3_0000, 8'h00);
    // Empty RX with a same-cycle host push returns 0 and keeps the byte
    rd(32'h3_0000, 8'h00); in_rx_valid = 1'b1; in_rx_data = 8'h77;
    rd(32'h3_0000, 8'h77); in_rx_valid = 1'b0;

    // RX full: ninth offered byte is refused
    for (int i = 0; i < 9; i++) begin
      idle(); in_rx_valid = 1'b1; in_rx_data = 8'h80 + 8'(i);
    end
    idle(); in_rx_valid = 1'b0;
    checkOutput("rx_ready_full", {31'd0, out_rx_ready}, 32'd0);
    rd(32'h3_0004, 8'h02);
    for (int i = 0; i < 8; i++) rd(32'h3_0000, 8'h80 + 8'(i));
    rd(32'h3_0000, 8'h00);

    // Unmapped MMIO offsets
    wr(32'h3_0010, 8'hFF);
    rd(32'h3_0010, 8'h00);
    rd(32'h3_0005, 8'h00);

`ifdef CYCLE_COUNTER_EN
    // Coherent 4-byte counter read, with gaps so the live counter moves on
    applyStimulus(1'b1, 1'b0, 32'h3_0008, 8'h00, 8'h00);
    snap = ref_cnt;
    void'(rd_q.pop_back());
    rd_q.push_back(snap[7:0]);
    idle();
    idle();
    rd(32'h3_0009, snap[15:8]);
    rd(32'h3_000A, snap[23:16]);
    idle();
    rd(32'h3_000B, snap[31:24]);
`else
    snap = 32'h0;
    rd(32'h3_0008, snap[7:0]);
    rd(32'h3_0009, 8'h00);
    rd(32'h3_000B, 8'h00);
`endif

    // Halt is sticky until reset
    wr(32'h3_0004, 8'h00);
    idle();
    checkOutput("halt_set", {31'd0, out_halt}, 32'd1);
    idle();
    idle();
    checkOutput("halt_sticky", {31'd0, out_halt}, 32'd1);

    // Asynchronous reset with TX non-empty and a RAM write in flight
    in_tx_ready = 1'b0;
    wr(32'h3_0000, 8'h21);
    wr(32'h3_0000, 8'h22);
    rd(32'h0000_0100, 8'h55);
    idle();
    checkOutput("tx_valid_pre_reset", {31'd0, out_tx_valid}, 32'd1);
    wr(32'h0000_0100, 8'hEE);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_halt", {31'd0, out_halt}, 32'd0);
    checkOutput("async_rst_tx_valid", {31'd0, out_tx_valid}, 32'd0);
    checkOutput("async_rst_io_full", {31'd0, out_io_full}, 32'd0);
    checkOutput("async_rst_rx_ready", {31'd0, out_rx_ready}, 32'd1);
    checkOutput("async_rst_ram_data", {24'd0, bus.out_ram_data}, 32'd0);
    @(posedge clk); #1;
    bus.in_ram_ena = 1'b0;
    rst = 1'b0;
    rd(32'h0000_0100, 8'h55);
    rd(32'h3_0004, 8'h00);
    idle();
    idle();
    checkOutput("rd_queue_empty", rd_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
